ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Parametrised multi-cycle controller for the nibble-opcode CPU. It replaces the single-edge controller with an explicit fetch/execute/store state machine. The block latches each instruction into an internal instruction register and drives one-cycle ALU enables. Stores complete through either a memory-acknowledge handshake or a fixed-latency counter. It sits between instruction memory and the datapath (ALU, register file, 16-bit register pairs) and adds a HALT state.

## Interface
Parameters:
- `INSTR_W`, default 8: instruction width; operand width `OPR_W = INSTR_W - OPC_W`, must be even and ≥ 4.
- `OPC_W`, default 4: opcode width; opcode = `IR[INSTR_W-1 -: OPC_W]`.
- `SHAMT_W`, default 3: shift amount width, ≤ `OPR_W`.
- `OPC_STB`, default 4'b1110: store opcode.
- `OPC_HALT`, default 4'b1111: halt opcode.
- `STB_LAT`, default 0: 0 = store ends on `mem_ack`; N ≥ 1 = store lasts exactly N cycles and `mem_ack` is ignored.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in `INSTR_W`: instruction from memory.
- `instr_valid` in 1: `instr` valid; sampled only in FETCH.
- `mem_ack` in 1: store complete; sampled only in STORE when `STB_LAT` = 0.
- `alu_op` out `OPC_W-1`: `IR opcode[OPC_W-2:0]`.
- `alu_shamt` out `SHAMT_W`: `IR operand[SHAMT_W-1:0]`.
- `alu_en` out 1: one-cycle ALU strobe.
- `fetch` out 1: instruction fetch request.
- `nibble_out` out `OPR_W`: IR operand.
- `reg_sel` out `OPR_W`: IR operand.
- `reg16_src` out `OPR_W/2`: operand upper half.
- `reg16_dst` out `OPR_W/2`: operand lower half.
- `we` out 1: data-memory write enable.
- `halted` out 1: core halted.

## Operation
- States: FETCH, EXEC, STORE, HALT. Encoding is free; outputs are Moore (state + IR only), with no combinational path from inputs.
- FETCH: `fetch`=1. On a rising edge with `instr_valid`=1, latch `IR <= instr` and go to EXEC. Otherwise stay in FETCH; IR holds its old value.
- EXEC: decode IR; exactly one cycle.
  - Opcode MSB = 0 (arithmetic class): `alu_en`=1 this cycle, then go to FETCH.
  - Opcode = `OPC_STB`: go to STORE; load the wait counter with `STB_LAT-1` if `STB_LAT` > 0.
  - Opcode = `OPC_HALT`: go to HALT.
  - Any other opcode: no strobe, go to FETCH.
- STORE: `we`=1, `fetch`=0.
  - `STB_LAT` = 0: stay until `mem_ack`=1 is sampled, then go to FETCH. There is no timeout.
  - `STB_LAT` = N: the counter decrements each cycle; go to FETCH when it reads 0. `we` is high for exactly N cycles.
- HALT: `halted`=1, `fetch`=0, `we`=0, `alu_en`=0. Only `rst` leaves HALT.
- Operand fields (`nibble_out`, `reg_sel`, `reg16_*`, `alu_op`, `alu_shamt`) are wired from IR. They are stable from EXEC until the next IR load.
- `alu_en` and `we` are never high in the same cycle; `fetch` is high only in FETCH.
- Counter width is `$clog2(STB_LAT+1)`, minimum 1 bit. A counter at 0 never wraps.

## Timing
- Reset values (asynchronous, immediate): state = FETCH, IR = 0, `fetch`=1, `we`=0, `alu_en`=0, `halted`=0. All IR-derived outputs are 0.
- Reset mid-STORE drops `we` immediately. Reset in HALT returns to FETCH.
- The first edge after `rst` deasserts may accept an instruction.
- ALU or other single-cycle instruction: 2 cycles from the accepting edge back to FETCH, given back-to-back `instr_valid`.
- Store:
  - `STB_LAT` = 0: 2 + k cycles, where k ≥ 1 is the number of STORE cycles up to and including the cycle `mem_ack` is sampled.
  - `STB_LAT` = N: 2 + N cycles.
- `mem_ack` already high on entry to STORE completes the store after one cycle.
- `instr_valid` held high in EXEC or STORE is ignored and does not update IR.
- `mem_ack` outside STORE is ignored.

## Test plan
- Reset then ALU op: assert `rst` asynchronously mid-cycle, then instr 8'h35 with `instr_valid` held 1 → outputs take reset values without a clock edge; after release, `alu_en` pulses one cycle, `alu_op`=3'b011, `alu_shamt`=3'b101; `fetch` returns 1 the cycle after.
- Store with handshake (`STB_LAT`=0): instr 8'hE6, `mem_ack` raised 3 cycles into STORE → `we` high exactly 4 cycles; `fetch` low throughout; `reg16_src`=2'b01, `reg16_dst`=2'b10.
- Store with fixed latency (`STB_LAT`=2): instr 8'hE0, `mem_ack` toggling randomly → `we` high exactly 2 cycles; `mem_ack` has no effect.
- Stalled fetch: `instr_valid`=0 for 5 cycles, then 8'h92 → `fetch` high all 6 cycles, IR unchanged until the accepting edge, no `alu_en`.
- Halt: instr 8'hF0, then `instr_valid` pulses → `halted`=1 and `fetch`=0 indefinitely, IR frozen; `rst` returns to FETCH.
- Reset mid-store: assert `rst` in the 2nd STORE cycle → `we` drops immediately and `fetch`=1.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/execute/store controller for the nibble-opcode CPU.
// Latches instructions into IR and sequences ALU strobes, stores and halt.
`timescale 1ns/1ps
module ctrl_seq #(
   parameter int                 INSTR_W  = 8,
   parameter int                 OPC_W    = 4,
   parameter int                 SHAMT_W  = 3,
   parameter logic [OPC_W-1:0]   OPC_STB  = 4'b1110,
   parameter logic [OPC_W-1:0]   OPC_HALT = 4'b1111,
   parameter int                 STB_LAT  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [INSTR_W-1:0]         instr,
   input  logic                       instr_valid,
   input  logic                       mem_ack,
   output logic [OPC_W-2:0]           alu_op,
   output logic [SHAMT_W-1:0]         alu_shamt,
   output logic                       alu_en,
   output logic                       fetch,
   output logic [INSTR_W-OPC_W-1:0]   nibble_out,
   output logic [INSTR_W-OPC_W-1:0]   reg_sel,
   output logic [(INSTR_W-OPC_W)/2-1:0] reg16_src,
   output logic [(INSTR_W-OPC_W)/2-1:0] reg16_dst,
   output logic                       we,
   output logic                       halted
);

   localparam int OPR_W = INSTR_W - OPC_W;
   localparam int HALF_W = OPR_W / 2;
   localparam int CNT_W = (STB_LAT > 0) ? $clog2(STB_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (STB_LAT > 0) ? CNT_W'(STB_LAT - 1) : '0;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_STORE = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]         state;
   logic [1:0]         state_n;
   logic [INSTR_W-1:0] ir;
   logic [CNT_W-1:0]   cnt;
   logic [OPC_W-1:0]   opc;
   logic [OPR_W-1:0]   opr;
   logic               store_done;

   assign opc = ir[INSTR_W-1 -: OPC_W];
   assign opr = ir[OPR_W-1:0];

   // Fixed-latency stores ignore the handshake entirely
   assign store_done = (STB_LAT == 0) ? mem_ack : (cnt == '0);

   always_comb begin
      state_n = state;
      case (state)
         S_FETCH: if (instr_valid) state_n = S_EXEC;
         S_EXEC: begin
            if (!opc[OPC_W-1])       state_n = S_FETCH;
            else if (opc == OPC_STB)  state_n = S_STORE;
            else if (opc == OPC_HALT) state_n = S_HALT;
            else                      state_n = S_FETCH;
         end
         S_STORE: if (store_done) state_n = S_FETCH;
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         ir    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state == S_FETCH && instr_valid)
            ir <= instr;
         if (state == S_EXEC)
            cnt <= CNT_INIT;
         else if (state == S_STORE && cnt != '0)
            cnt <= cnt - CNT_W'(1);
      end
   end

   assign fetch  = (state == S_FETCH);
   assign alu_en = (state == S_EXEC) && !opc[OPC_W-1];
   assign we     = (state == S_STORE);
   assign halted = (state == S_HALT);

   assign alu_op     = opc[OPC_W-2:0];
   assign alu_shamt  = opr[SHAMT_W-1:0];
   assign nibble_out = opr;
   assign reg_sel    = opr;
   assign reg16_src  = opr[OPR_W-1 -: HALF_W];
   assign reg16_dst  = opr[HALF_W-1:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: handshake and fixed-latency instances against a
// cycle-level behavioural model, plus directed literal checks.
`timescale 1ns/1ps
module tb_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instr = 8'h00;
   logic       instr_valid = 1'b0;
   logic       mem_ack = 1'b0;

   logic [2:0] alu_op [2];
   logic [2:0] alu_shamt [2];
   logic       alu_en [2];
   logic       fetch [2];
   logic [3:0] nibble_out [2];
   logic [3:0] reg_sel [2];
   logic [1:0] reg16_src [2];
   logic [1:0] reg16_dst [2];
   logic       we [2];
   logic       halted [2];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ctrl_seq #(.STB_LAT(0)) u0 (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .mem_ack(mem_ack), .alu_op(alu_op[0]), .alu_shamt(alu_shamt[0]),
      .alu_en(alu_en[0]), .fetch(fetch[0]), .nibble_out(nibble_out[0]),
      .reg_sel(reg_sel[0]), .reg16_src(reg16_src[0]),
      .reg16_dst(reg16_dst[0]), .we(we[0]), .halted(halted[0])
   );

   ctrl_seq #(.STB_LAT(2)) u1 (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .mem_ack(mem_ack), .alu_op(alu_op[1]), .alu_shamt(alu_shamt[1]),
      .alu_en(alu_en[1]), .fetch(fetch[1]), .nibble_out(nibble_out[1]),
      .reg_sel(reg_sel[1]), .reg16_src(reg16_src[1]),
      .reg16_dst(reg16_dst[1]), .we(we[1]), .halted(halted[1])
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic int lat(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   // Model: pending exec beat, store beats remaining, ack wait, halt flag
   logic [7:0] m_ir [2] = '{8'h00, 8'h00};
   bit         m_exec [2];
   bit         m_wack [2];
   bit         m_halt [2];
   int         m_left [2];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_ir[i] <= 8'h00;
            m_exec[i] <= 1'b0;
            m_wack[i] <= 1'b0;
            m_halt[i] <= 1'b0;
            m_left[i] <= 0;
         end else if (m_halt[i]) begin
            m_halt[i] <= 1'b1;
         end else if (m_exec[i]) begin
            m_exec[i] <= 1'b0;
            if (m_ir[i][7:4] == 4'hE) begin
               if (lat(i) == 0) m_wack[i] <= 1'b1;
               else m_left[i] <= lat(i);
            end else if (m_ir[i][7:4] == 4'hF) begin
               m_halt[i] <= 1'b1;
            end
         end else if (m_wack[i]) begin
            m_wack[i] <= !mem_ack;
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
         end else if (instr_valid) begin
            m_ir[i] <= instr;
            m_exec[i] <= 1'b1;
         end
      end
   end

   function automatic logic [21:0] expv(input int i);
      logic [7:0] r;
      logic       f;
      logic       w;
      r = m_ir[i];
      f = !m_exec[i] && !m_wack[i] && (m_left[i] == 0) && !m_halt[i];
      w = m_wack[i] || (m_left[i] > 0);
      return {r[6:4], r[2:0], m_exec[i] && !r[7], f, r[3:0], r[3:0],
              r[3:2], r[1:0], w, m_halt[i]};
   endfunction

   function automatic logic [21:0] actv(input int i);
      return {alu_op[i], alu_shamt[i], alu_en[i], fetch[i], nibble_out[i],
              reg_sel[i], reg16_src[i], reg16_dst[i], we[i], halted[i]};
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         chk($sformatf("model_u%0d", i), 32'(actv(i)), 32'(expv(i)));
   end

   task automatic tick;
      @(negedge clk);
   endtask

   int nwe0;
   int nwe1;
   int nf;

   initial begin
      repeat (2) tick;
      #2 rst = 1'b0;

      // stalled fetch, then 8'h92 accepted
      for (int k = 0; k < 6; k++) begin
         tick;
         chk("stall_fetch", 32'(fetch[0]), 1);
         chk("stall_alu_en", 32'(alu_en[0]), 0);
         chk("stall_ir", 32'(nibble_out[0]), 0);
         if (k == 5) begin
            instr = 8'h92;
            instr_valid = 1'b1;
         end
      end
      tick;
      instr_valid = 1'b0;
      chk("exec92_alu_en", 32'(alu_en[0]), 0);
      chk("exec92_nib", 32'(nibble_out[0]), 4'h2);
      chk("exec92_fetch", 32'(fetch[0]), 0);
      tick;
      chk("after92_fetch", 32'(fetch[0]), 1);

      // async reset mid-cycle, then ALU op 8'h35
      instr = 8'h35;
      instr_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_fetch", 32'(fetch[0]), 1);
      chk("async_rst_ir", 32'(nibble_out[0]), 0);
      chk("async_rst_alu_en", 32'(alu_en[0]), 0);
      tick;
      #2 rst = 1'b0;
      tick;
      instr_valid = 1'b0;
      chk("alu35_en", 32'(alu_en[0]), 1);
      chk("alu35_op", 32'(alu_op[0]), 3'b011);
      chk("alu35_shamt", 32'(alu_shamt[0]), 3'b101);
      chk("alu35_fetch", 32'(fetch[0]), 0);
      tick;
      chk("alu35_end_en", 32'(alu_en[0]), 0);
      chk("alu35_end_fetch", 32'(fetch[0]), 1);

      // store 8'hE6, ack raised in the 4th STORE cycle
      instr = 8'hE6;
      instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0;
      chk("stb_src", 32'(reg16_src[0]), 2'b01);
      chk("stb_dst", 32'(reg16_dst[0]), 2'b10);
      chk("stb_exec_we", 32'(we[0]), 0);
      nwe0 = 0; nwe1 = 0; nf = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         nwe0 += int'(we[0]);
         nwe1 += int'(we[1]);
         if (we[0]) nf += int'(fetch[0]);
         mem_ack = (k == 3);
      end
      chk("stb_hs_we_cycles", nwe0, 4);
      chk("stb_lat2_we_cycles", nwe1, 2);
      chk("stb_fetch_low", nf, 0);

      // fixed latency with random ack
      instr = 8'hE0;
      instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0;
      nwe1 = 0;
      for (int k = 0; k < 8; k++) begin
         mem_ack = 1'($urandom_range(0, 1));
         tick;
         nwe1 += int'(we[1]);
      end
      chk("stb_lat2_rand_ack", nwe1, 2);
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      tick;

      // reset in 2nd STORE cycle
      instr = 8'hE6;
      instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0;
      tick;
      tick;
      chk("pre_rst_store_we", 32'(we[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_store_we0", 32'(we[0]), 0);
      chk("rst_store_we1", 32'(we[1]), 0);
      chk("rst_store_fetch", 32'(fetch[0]), 1);
      tick;
      #2 rst = 1'b0;

      // halt, pulses on instr_valid ignored
      tick;
      instr = 8'hF0;
      instr_valid = 1'b1;
      tick;
      for (int k = 0; k < 10; k++) begin
         instr = 8'($urandom);
         instr_valid = (k % 2) == 0;
         tick;
         chk("halt_halted", 32'(halted[0]), 1);
         chk("halt_fetch", 32'(fetch[0]), 0);
         chk("halt_ir_op", 32'(alu_op[0]), 3'b111);
         chk("halt_ir_nib", 32'(nibble_out[1]), 0);
      end
      instr_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("halt_rst_halted", 32'(halted[0]), 0);
      chk("halt_rst_fetch", 32'(fetch[1]), 1);
      tick;
      #2 rst = 1'b0;

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         tick;
         instr = 8'($urandom);
         if (instr[7:4] == 4'hF && $urandom_range(0, 9) != 0)
            instr[7:4] = 4'hE;
         instr_valid = 1'($urandom_range(0, 1));
         mem_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #2 rst = 1'b1;
            #1;
            chk("rand_rst_fetch", 32'(fetch[0]), 1);
            #5 rst = 1'b0;
         end
      end
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
